// File: rtl/lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : lsu_pkg                                                 |
// | Brief  : Shared constants, state encoding and decode helpers for |
// |          the load/store unit.                                    |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
package lsu_pkg;

  // RV32 load/store funct3 encodings (stores reuse the signed codes)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Default MMIO window: one 256-byte page that only tolerates aligned accesses
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0010_0000;
  localparam logic [31:0] MMIO_MASK_DEFAULT = 32'hFFFF_FF00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Access width in bytes; illegal codes fall into the word bucket and are
  // rejected separately by funct3_illegal.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  // Codes with no RV32 meaning, plus unsigned variants that stores lack
  function automatic logic funct3_illegal(input logic [2:0] funct3, input logic is_store);
    return (funct3[1:0] == 2'b11) || (funct3 == 3'b110) || (is_store && funct3[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : lsu_lane_align                                          |
// | Brief  : Combinational byte-lane steering: byte selects and      |
// |          shifted store data for both halves of an access, plus   |
// |          merge and sign/zero extension of load data.             |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [3:0]  o_sel0,
  output logic [3:0]  o_sel1,
  output logic [31:0] o_wdata0,
  output logic [31:0] o_wdata1,
  output logic [31:0] o_load_data
);

  logic [3:0]  w_mask;
  logic [2:0]  w_hi_shift;
  logic [31:0] w_merged;

  // Lane masks/data for the low word (shift up by off) and the spill-over
  // into the next word (shift down by 4-off; off=0 shifts everything out).
  always_comb begin
    case (size_bytes(i_funct3))
      3'd1:    w_mask = 4'b0001;
      3'd2:    w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
    w_hi_shift = 3'd4 - {1'b0, i_off};
    o_sel0     = w_mask << i_off;
    o_sel1     = w_mask >> w_hi_shift;
    o_wdata0   = i_wdata << {i_off, 3'b000};
    o_wdata1   = i_wdata >> {w_hi_shift, 3'b000};
  end

  // Load result: pick the bytes starting at off from the {hi,lo} pair, then
  // extend; funct3[2] selects zero extension.
  always_comb begin
    w_merged = 32'({i_hi, i_lo} >> {i_off, 3'b000});
    case (size_bytes(i_funct3))
      3'd1:    o_load_data = {{24{w_merged[7]  & ~i_funct3[2]}}, w_merged[7:0]};
      3'd2:    o_load_data = {{16{w_merged[15] & ~i_funct3[2]}}, w_merged[15:0]};
      default: o_load_data = w_merged;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : load_store_unit                                         |
// | Brief  : Data-memory initiator. One request per handshake, split |
// |          of misaligned accesses into two aligned word accesses,  |
// |          fault reporting and extended load data.                 |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter logic [31:0] MMIO_BASE        = MMIO_BASE_DEFAULT,
  parameter logic [31:0] MMIO_MASK        = MMIO_MASK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [3:0]  mem_byte_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        fault_q, fault_d;
  logic        split_q, split_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;

  logic [2:0]  w_req_end;
  logic        w_req_misaligned;
  logic        w_req_mmio;
  logic        w_req_fault;
  logic        w_req_split;
  logic [3:0]  w_sel0, w_sel1;
  logic [31:0] w_wdata0, w_wdata1;
  logic [31:0] w_load_data;
  logic [31:0] w_resp_data;
  logic [31:0] w_word_addr;

  // Classify the incoming request from the live request bus so the decision
  // is ready at the accept edge.
  always_comb begin
    w_req_end        = {1'b0, req_addr[1:0]} + size_bytes(req_funct3);
    w_req_misaligned = (w_req_end > 3'd4);
    w_req_mmio       = ((req_addr & MMIO_MASK) == MMIO_BASE);
    w_req_fault      = funct3_illegal(req_funct3, req_store) ||
                       (w_req_misaligned && (!ALLOW_MISALIGNED || w_req_mmio));
    w_req_split      = w_req_misaligned && !w_req_fault;
  end

  lsu_lane_align u_lane_align (
    .i_funct3    (funct3_q),
    .i_off       (addr_q[1:0]),
    .i_wdata     (wdata_q),
    .i_lo        (lo_q),
    .i_hi        (hi_q),
    .o_sel0      (w_sel0),
    .o_sel1      (w_sel1),
    .o_wdata0    (w_wdata0),
    .o_wdata1    (w_wdata1),
    .o_load_data (w_load_data)
  );

  // Stores and faults report zero data; the word-aligned base of the access.
  always_comb begin
    w_resp_data = (store_q || fault_q) ? 32'd0 : w_load_data;
    w_word_addr = {addr_q[31:2], 2'b00};
  end

  // Next-state and datapath updates: latch on accept, capture read data in
  // the access states, publish the response in DONE.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    fault_d      = fault_q;
    split_d      = split_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          fault_d  = w_req_fault;
          split_d  = w_req_split;
          state_d  = w_req_fault ? ST_DONE : ST_ACC0;
        end
      end
      ST_ACC0: begin
        if (!store_q) lo_d = mem_rdata;
        state_d = split_q ? ST_ACC1 : ST_DONE;
      end
      ST_ACC1: begin
        if (!store_q) hi_d = mem_rdata;
        state_d = ST_DONE;
      end
      default: begin
        resp_rdata_d = w_resp_data;
        resp_fault_d = fault_q;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // Port outputs decoded from state so that reset silences the memory bus
  // immediately; response fields hold their last value outside DONE.
  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    resp_valid   = 1'b0;
    resp_rdata   = resp_rdata_q;
    resp_fault   = resp_fault_q;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_byte_sel = 4'b0000;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    case (state_q)
      ST_ACC0: begin
        mem_read_en  = !store_q;
        mem_write_en = store_q;
        mem_byte_sel = w_sel0;
        mem_addr     = w_word_addr;
        mem_wdata    = w_wdata0;
      end
      ST_ACC1: begin
        mem_read_en  = !store_q;
        mem_write_en = store_q;
        mem_byte_sel = w_sel1;
        mem_addr     = w_word_addr + 32'd4;
        mem_wdata    = w_wdata1;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_rdata = w_resp_data;
        resp_fault = fault_q;
      end
      default: ;
    endcase
  end

  // State and buffer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      lo_q         <= 32'd0;
      hi_q         <= 32'd0;
      fault_q      <= 1'b0;
      split_q      <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      fault_q      <= fault_d;
      split_q      <= split_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_load_store_unit                                      |
// | Brief  : Self-checking bench for load_store_unit: directed       |
// |          vector table, reset/hold sequences and random traffic   |
// |          against a byte-level memory model.                      |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_sel = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic        a_req_valid, b_req_valid;
  logic        a_req_ready, a_resp_valid, a_resp_fault, a_mem_read_en, a_mem_write_en;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_byte_sel;
  logic        b_req_ready, b_resp_valid, b_resp_fault, b_mem_read_en, b_mem_write_en;
  logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_byte_sel;

  logic [31:0] tbmem [64];
  logic [7:0]  bmem  [256];

  int tests  = 0;
  int errors = 0;

  logic [3:0]  acc_sel  [2];
  logic [31:0] acc_addr [2];
  logic [31:0] acc_wd   [2];
  logic        acc_we   [2];

  always #5 clk = ~clk;

  assign a_req_valid = req_valid & ~req_sel;
  assign b_req_valid = req_valid &  req_sel;
  assign a_mem_rdata = tbmem[a_mem_addr[7:2]];
  assign b_mem_rdata = 32'h1357_2468;

  load_store_unit dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_fault(a_resp_fault),
    .mem_read_en(a_mem_read_en), .mem_write_en(a_mem_write_en), .mem_byte_sel(a_mem_byte_sel),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_fault(b_resp_fault),
    .mem_read_en(b_mem_read_en), .mem_write_en(b_mem_write_en), .mem_byte_sel(b_mem_byte_sel),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Clocked-write memory, 256 bytes aliased over the whole address space
  always @(posedge clk) begin
    if (a_mem_write_en) begin
      logic [31:0] m;
      m = {{8{a_mem_byte_sel[3]}}, {8{a_mem_byte_sel[2]}},
           {8{a_mem_byte_sel[1]}}, {8{a_mem_byte_sel[0]}}};
      tbmem[a_mem_addr[7:2]] <= (tbmem[a_mem_addr[7:2]] & ~m) | (a_mem_wdata & m);
    end
  end

  // Bus invariants checked every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if ((a_mem_read_en && a_mem_write_en) || (a_mem_addr[1:0] != 2'b00) ||
          ((a_req_ready || a_resp_valid) && (a_mem_read_en || a_mem_write_en))) begin
        errors++;
        $display("FAIL bus_invariant t=%0t re=%b we=%b addr=%h ready=%b rv=%b",
                 $time, a_mem_read_en, a_mem_write_en, a_mem_addr, a_req_ready, a_resp_valid);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request to the selected instance, record memory accesses and
  // measure cycles from the accept edge to resp_valid.
  task automatic run_op(input bit which, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit flt, output int lat, output int nacc);
    @(negedge clk);
    req_sel = which; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; nacc = 0; rd = 32'd0; flt = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (which ? b_resp_valid : a_resp_valid) begin
        lat = c;
        rd  = which ? b_resp_rdata : a_resp_rdata;
        flt = which ? b_resp_fault : a_resp_fault;
        break;
      end
      if (which ? (b_mem_read_en | b_mem_write_en) : (a_mem_read_en | a_mem_write_en)) begin
        if (nacc < 2) begin
          acc_sel[nacc]  = which ? b_mem_byte_sel : a_mem_byte_sel;
          acc_addr[nacc] = which ? b_mem_addr     : a_mem_addr;
          acc_wd[nacc]   = which ? b_mem_wdata    : a_mem_wdata;
          acc_we[nacc]   = which ? b_mem_write_en : a_mem_write_en;
        end
        nacc++;
      end
      @(negedge clk);
    end
    if (lat == 0) begin
      tests++; errors++;
      $display("FAIL resp_timeout: got no resp_valid within 8 cycles, expected one (addr %h)", a);
    end
  endtask

  // Reference: byte-addressed memory, access rules applied per byte
  task automatic model_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output bit flt,
                          output int lat, output int nacc);
    int size;
    bit illegal, mis, mmio;
    logic [31:0] v;
    logic [7:0] idx;
    case (f3[1:0])
      2'b00:   size = 1;
      2'b01:   size = 2;
      default: size = 4;
    endcase
    illegal = (f3[1:0] == 2'b11) || (f3 == 3'b110) || (st && f3[2]);
    mis  = (int'(a[1:0]) + size) > 4;
    mmio = (a & 32'hFFFF_FF00) == 32'h0010_0000;
    flt  = illegal || (mis && mmio);
    rd   = 32'd0;
    lat  = flt ? 1 : (mis ? 3 : 2);
    nacc = flt ? 0 : (mis ? 2 : 1);
    if (!flt) begin
      if (st) begin
        for (int i = 0; i < size; i++) begin
          idx = 8'(a + 32'(i));
          bmem[idx] = wd[8*i +: 8];
        end
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) begin
          idx = 8'(a + 32'(i));
          v[8*i +: 8] = bmem[idx];
        end
        if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  typedef struct {
    bit          w;
    bit          s;
    logic [2:0]  f;
    logic [31:0] a, wd, rd;
    bit          fl;
    int          lt, na;
    logic [3:0]  s0;
    logic [31:0] a0, wd0;
    logic [3:0]  s1;
    logic [31:0] a1, wd1;
  } vec_t;

  function automatic vec_t mkv(bit w, bit s, logic [2:0] f, logic [31:0] a, logic [31:0] wd,
                               logic [31:0] rd, bit fl, int lt, int na,
                               logic [3:0] s0, logic [31:0] a0, logic [31:0] wd0,
                               logic [3:0] s1, logic [31:0] a1, logic [31:0] wd1);
    vec_t v;
    v.w = w; v.s = s; v.f = f; v.a = a; v.wd = wd; v.rd = rd; v.fl = fl; v.lt = lt; v.na = na;
    v.s0 = s0; v.a0 = a0; v.wd0 = wd0; v.s1 = s1; v.a1 = a1; v.wd1 = wd1;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[$];
    logic [31:0] rd, erd;
    bit          fl, efl;
    int          lt, na, elt, ena;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    bit          seen;

    // Fields: dut, store, funct3, addr, wdata | rdata, fault, lat, naccess | sel0, addr0, wd0 | sel1, addr1, wd1
    vt.push_back(mkv(0,1,3'b010,32'h20000010,32'hDEADBEEF, 32'h0,0,2,1, 4'hF,32'h20000010,32'hDEADBEEF, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,0,3'b010,32'h20000010,32'h0, 32'hDEADBEEF,0,2,1, 4'hF,32'h20000010,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,1,3'b010,32'h20000010,32'h80112233, 32'h0,0,2,1, 4'hF,32'h20000010,32'h80112233, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,0,3'b000,32'h20000013,32'h0, 32'hFFFFFF80,0,2,1, 4'h8,32'h20000010,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,0,3'b100,32'h20000013,32'h0, 32'h00000080,0,2,1, 4'h8,32'h20000010,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,1,3'b000,32'h20000011,32'h123456AB, 32'h0,0,2,1, 4'h2,32'h20000010,32'h3456AB00, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,0,3'b010,32'h20000010,32'h0, 32'h8011AB33,0,2,1, 4'hF,32'h20000010,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,1,3'b010,32'h20000004,32'hAABBCCDD, 32'h0,0,2,1, 4'hF,32'h20000004,32'hAABBCCDD, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,1,3'b010,32'h20000008,32'h11223344, 32'h0,0,2,1, 4'hF,32'h20000008,32'h11223344, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,0,3'b010,32'h20000006,32'h0, 32'h3344AABB,0,3,2, 4'hC,32'h20000004,32'h0, 4'h3,32'h20000008,32'h0));
    vt.push_back(mkv(0,1,3'b001,32'h20000007,32'h0000BEEF, 32'h0,0,3,2, 4'h8,32'h20000004,32'hEF000000, 4'h1,32'h20000008,32'h000000BE));
    vt.push_back(mkv(0,0,3'b101,32'h20000007,32'h0, 32'h0000BEEF,0,3,2, 4'h8,32'h20000004,32'h0, 4'h1,32'h20000008,32'h0));
    vt.push_back(mkv(0,0,3'b001,32'h20000007,32'h0, 32'hFFFFBEEF,0,3,2, 4'h8,32'h20000004,32'h0, 4'h1,32'h20000008,32'h0));
    vt.push_back(mkv(0,0,3'b010,32'h00100002,32'h0, 32'h0,1,1,0, 4'h0,32'h0,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,0,3'b011,32'h20000010,32'h0, 32'h0,1,1,0, 4'h0,32'h0,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,1,3'b100,32'h20000010,32'h5, 32'h0,1,1,0, 4'h0,32'h0,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,1,3'b010,32'h00100000,32'h12348765, 32'h0,0,2,1, 4'hF,32'h00100000,32'h12348765, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,0,3'b001,32'h00100000,32'h0, 32'hFFFF8765,0,2,1, 4'h3,32'h00100000,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,0,3'b001,32'h00100002,32'h0, 32'h00001234,0,2,1, 4'hC,32'h00100000,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,0,3'b001,32'h001000FF,32'h0, 32'h0,1,1,0, 4'h0,32'h0,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,1,3'b010,32'hFFFFFFFC,32'hCAFEF00D, 32'h0,0,2,1, 4'hF,32'hFFFFFFFC,32'hCAFEF00D, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(0,0,3'b010,32'hFFFFFFFE,32'h0, 32'h8765CAFE,0,3,2, 4'hC,32'hFFFFFFFC,32'h0, 4'h3,32'h00000000,32'h0));
    vt.push_back(mkv(1,0,3'b001,32'h20000003,32'h0, 32'h0,1,1,0, 4'h0,32'h0,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(1,0,3'b010,32'h20000000,32'h0, 32'h13572468,0,2,1, 4'hF,32'h20000000,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(1,0,3'b001,32'h20000002,32'h0, 32'h00001357,0,2,1, 4'hC,32'h20000000,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(1,0,3'b101,32'h20000001,32'h0, 32'h00005724,0,2,1, 4'h6,32'h20000000,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(1,0,3'b010,32'h20000001,32'h0, 32'h0,1,1,0, 4'h0,32'h0,32'h0, 4'h0,32'h0,32'h0));
    vt.push_back(mkv(1,1,3'b010,32'h20000006,32'h1, 32'h0,1,1,0, 4'h0,32'h0,32'h0, 4'h0,32'h0,32'h0));

    // Reset state, both during and after reset
    repeat (2) @(negedge clk);
    chk("rst_ready",    32'(a_req_ready),  32'd1);
    chk("rst_rvalid",   32'(a_resp_valid), 32'd0);
    chk("rst_rdata",    a_resp_rdata,      32'd0);
    chk("rst_fault",    32'(a_resp_fault), 32'd0);
    chk("rst_mem_ctl",  {26'd0, a_mem_read_en, a_mem_write_en, a_mem_byte_sel}, 32'd0);
    chk("rst_mem_addr", a_mem_addr,  32'd0);
    chk("rst_mem_wd",   a_mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(a_req_ready), 32'd1);

    // Directed vector table
    foreach (vt[k]) begin
      run_op(vt[k].w, vt[k].s, vt[k].f, vt[k].a, vt[k].wd, rd, fl, lt, na);
      chk($sformatf("vec%0d_rdata", k), rd, vt[k].rd);
      chk($sformatf("vec%0d_fault", k), 32'(fl), 32'(vt[k].fl));
      chk($sformatf("vec%0d_latency", k), 32'(lt), 32'(vt[k].lt));
      chk($sformatf("vec%0d_accesses", k), 32'(na), 32'(vt[k].na));
      if (na >= 1 && vt[k].na >= 1) begin
        chk($sformatf("vec%0d_sel0", k), 32'(acc_sel[0]), 32'(vt[k].s0));
        chk($sformatf("vec%0d_addr0", k), acc_addr[0], vt[k].a0);
        chk($sformatf("vec%0d_we0", k), 32'(acc_we[0]), 32'(vt[k].s));
        if (vt[k].s) chk($sformatf("vec%0d_wdata0", k), acc_wd[0], vt[k].wd0);
      end
      if (na == 2 && vt[k].na == 2) begin
        chk($sformatf("vec%0d_sel1", k), 32'(acc_sel[1]), 32'(vt[k].s1));
        chk($sformatf("vec%0d_addr1", k), acc_addr[1], vt[k].a1);
        chk($sformatf("vec%0d_we1", k), 32'(acc_we[1]), 32'(vt[k].s));
        if (vt[k].s) chk($sformatf("vec%0d_wdata1", k), acc_wd[1], vt[k].wd1);
      end
    end

    // Response fields hold between responses
    run_op(0, 0, 3'b011, 32'h20000010, 32'h0, rd, fl, lt, na);
    @(negedge clk);
    chk("hold_fault_idle",  32'(a_resp_fault), 32'd1);
    chk("hold_rvalid_idle", 32'(a_resp_valid), 32'd0);
    run_op(0, 0, 3'b010, 32'h20000010, 32'h0, rd, fl, lt, na);
    @(negedge clk);
    @(negedge clk);
    chk("hold_rdata_idle", a_resp_rdata, 32'h8011AB33);
    chk("hold_fault_clr",  32'(a_resp_fault), 32'd0);

    // Reset during the second half of a split load
    @(negedge clk);
    req_sel = 1'b0; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20000006;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_acc0_sel", 32'(a_mem_byte_sel), 32'hC);
    @(negedge clk);
    chk("abort_acc1_sel", 32'(a_mem_byte_sel), 32'h3);
    rst = 1'b1;
    #1;
    chk("abort_enables", {30'd0, a_mem_read_en, a_mem_write_en}, 32'd0);
    chk("abort_rvalid",  32'(a_resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (a_resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    chk("abort_ready",   32'(a_req_ready), 32'd1);

    // Random traffic: seed all 64 words, then mixed ops, then a full sweep
    for (int w = 0; w < 64; w++) begin
      a  = 32'h20000000 + 32'(4 * w);
      wd = $urandom;
      model_op(1'b1, 3'b010, a, wd, erd, efl, elt, ena);
      run_op(0, 1'b1, 3'b010, a, wd, rd, fl, lt, na);
    end
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      a  = (($urandom % 8) == 0) ? 32'h00100000 : 32'h20000000;
      a  = a | 32'($urandom % 256);
      wd = $urandom;
      model_op(st, f3, a, wd, erd, efl, elt, ena);
      run_op(0, st, f3, a, wd, rd, fl, lt, na);
      chk($sformatf("rnd%0d_rdata(st=%0d f3=%0d a=%h)", n, st, f3, a), rd, erd);
      chk($sformatf("rnd%0d_fault", n), 32'(fl), 32'(efl));
      chk($sformatf("rnd%0d_latency", n), 32'(lt), 32'(elt));
      chk($sformatf("rnd%0d_accesses", n), 32'(na), 32'(ena));
    end
    for (int w = 0; w < 64; w++) begin
      a = 32'h20000000 + 32'(4 * w);
      model_op(1'b0, 3'b010, a, 32'h0, erd, efl, elt, ena);
      run_op(0, 1'b0, 3'b010, a, 32'h0, rd, fl, lt, na);
      chk($sformatf("sweep_word%0d", w), rd, erd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
